issue_queue_ooo: RTL and testbench
==================================

ISSUE_QUEUE_OOO -- requirements
Module: issue_queue_ooo

Interface
REQ-001 Parameter NUM_ENTRIES, default 16: queue depth, power of two, 4..64.
REQ-002 Parameter NUM_FU, default 3: functional units, one issue port each.
REQ-003 Parameter NUM_WB, default 2: wakeup/writeback broadcast ports.
REQ-004 Parameters DATA_W 32, PREG_W 6, ROB_W 6, FU_W = clog2(NUM_FU): operand, physical tag, ROB index and FU-select widths.
REQ-005 Derived ISSUE_W = 7+PREG_W+3*DATA_W+ROB_W; CNT_W = clog2(NUM_ENTRIES)+1.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 flush  in  1  discard all entries.
REQ-009 disp_valid  in  1; disp_ready  out  1: dispatch handshake.
REQ-010 disp_opcode in 7; disp_prd, disp_prs1, disp_prs2 in PREG_W; disp_rs1_rdy, disp_rs2_rdy in 1; disp_rs1_val, disp_rs2_val, disp_imm in DATA_W; disp_rob in ROB_W; disp_fu in FU_W.
REQ-011 wb_valid in NUM_WB; wb_tag in NUM_WB*PREG_W; wb_val in NUM_WB*DATA_W: packed broadcasts, port 0 in LSBs.
REQ-012 fu_ready  in  NUM_FU  unit k accepts an issue this cycle.
REQ-013 iss_valid  out  NUM_FU; iss_data  out  NUM_FU*ISSUE_W, each slice {opcode, prd, rs1_val, rs2_val, imm, rob}, opcode in MSBs.
REQ-014 count  out  CNT_W  occupied entries.

Function
REQ-015 Entry state: valid, fu, two ready bits, two tags, two values, opcode, prd, imm, rob, plus NUM_ENTRIES x NUM_ENTRIES age matrix.
REQ-016 disp_ready = (count < NUM_ENTRIES) && !flush, from registered count only; same-cycle issue does not raise it.
REQ-017 Dispatch fires when disp_valid && disp_ready at an edge; writes the lowest-index invalid entry and marks it younger than every valid entry.
REQ-018 At dispatch, a source with rdy=0 whose tag matches a valid wb port that cycle is captured ready with that wb_val.
REQ-019 Each edge, every valid entry with an unready source whose tag matches a valid wb port sets ready and latches wb_val; on multiple matches the lowest port wins.
REQ-020 Eligibility uses registered ready bits only: wakeup at edge E makes the entry selectable in the cycle after E.
REQ-021 Per FU k, with fu_ready[k]=1, select the oldest valid, fully ready entry with fu==k; at the edge, load iss_data slice k, set iss_valid[k]=1, clear entry valid.
REQ-022 iss_valid[k] is 0 in any cycle following an edge with no issue to unit k; up to NUM_FU issues per edge.
REQ-023 Minimum latency: entry dispatched ready at edge E appears on iss_valid at edge E+1.
REQ-024 An entry with disp_fu >= NUM_FU is never issued; occupancy stays until flush.
REQ-025 count updates each edge: +1 on dispatch, minus number of issues; simultaneous dispatch and issue at full leaves count at NUM_ENTRIES-issues+0 (dispatch blocked).
REQ-026 flush at an edge clears all valid bits and iss_valid, zeroes count, blocks dispatch; wakeups that cycle are discarded.

Reset
REQ-027 reset asserted: all valid bits, ready bits, age matrix, iss_valid, iss_data, count cleared to 0 immediately, independent of clk.
REQ-028 disp_ready = 1 the first cycle after reset deasserts; reset mid-operation drops all entries, no issue emitted.

Verification
REQ-029 Dispatch opcode 0x33, both rdy=1, rs1_val 5, rs2_val 7, fu 1, fu_ready=3'b111 -> iss_valid=3'b010 one cycle later, slice 1 carries vals 5 and 7.
REQ-030 Dispatch prs1=12 rdy=0; two cycles later wb tag 12 val 0xDEAD on port 1 -> entry issues the cycle after, rs1_val 0xDEAD.
REQ-031 Dispatch A then B, both ready, fu 0, fu_ready[0] held 0 then raised -> A issues first, B the next cycle.
REQ-032 16 dispatches with no issue -> count 16, disp_ready 0; 17th disp_valid ignored; one issue -> disp_ready 1 the cycle after.
REQ-033 Dispatch with prs2=9 rdy=0 while wb tag 9 val 3 is valid the same cycle -> entry ready, issues next cycle with rs2_val 3.
REQ-034 8 entries queued, flush asserted -> count 0, iss_valid 0 next cycle; later wb tags for those entries produce no issue.

Source files
------------

// File: rtl/issue_queue_ooo.sv
// Out-of-order issue queue: age-matrix oldest-ready select per functional unit,
// tag-broadcast wakeup, one registered issue slot per unit.
module issue_queue_ooo #(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_FU      = 3,
    parameter int NUM_WB      = 2,
    parameter int DATA_W      = 32,
    parameter int PREG_W      = 6,
    parameter int ROB_W       = 6,
    parameter int FU_W        = $clog2(NUM_FU),
    parameter int ISSUE_W     = 7 + PREG_W + 3*DATA_W + ROB_W,
    parameter int CNT_W       = $clog2(NUM_ENTRIES) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [6:0]                 disp_opcode,
    input  logic [PREG_W-1:0]          disp_prd,
    input  logic [PREG_W-1:0]          disp_prs1,
    input  logic [PREG_W-1:0]          disp_prs2,
    input  logic                       disp_rs1_rdy,
    input  logic                       disp_rs2_rdy,
    input  logic [DATA_W-1:0]          disp_rs1_val,
    input  logic [DATA_W-1:0]          disp_rs2_val,
    input  logic [DATA_W-1:0]          disp_imm,
    input  logic [ROB_W-1:0]           disp_rob,
    input  logic [FU_W-1:0]            disp_fu,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*PREG_W-1:0]   wb_tag,
    input  logic [NUM_WB*DATA_W-1:0]   wb_val,
    input  logic [NUM_FU-1:0]          fu_ready,
    output logic [NUM_FU-1:0]          iss_valid,
    output logic [NUM_FU*ISSUE_W-1:0]  iss_data,
    output logic [CNT_W-1:0]           count
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid;
    logic [NUM_ENTRIES-1:0] rdy1;
    logic [NUM_ENTRIES-1:0] rdy2;
    // older[j][i] = 1 when entry j was dispatched before entry i
    logic [NUM_ENTRIES-1:0] older [NUM_ENTRIES];

    logic [FU_W-1:0]   ent_fu     [NUM_ENTRIES];
    logic [PREG_W-1:0] ent_t1     [NUM_ENTRIES];
    logic [PREG_W-1:0] ent_t2     [NUM_ENTRIES];
    logic [DATA_W-1:0] ent_v1     [NUM_ENTRIES];
    logic [DATA_W-1:0] ent_v2     [NUM_ENTRIES];
    logic [6:0]        ent_opcode [NUM_ENTRIES];
    logic [PREG_W-1:0] ent_prd    [NUM_ENTRIES];
    logic [DATA_W-1:0] ent_imm    [NUM_ENTRIES];
    logic [ROB_W-1:0]  ent_rob    [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] wk1_hit;
    logic [NUM_ENTRIES-1:0] wk2_hit;
    logic [DATA_W-1:0]      wk1_val [NUM_ENTRIES];
    logic [DATA_W-1:0]      wk2_val [NUM_ENTRIES];
    logic                   dw1_hit;
    logic                   dw2_hit;
    logic [DATA_W-1:0]      dw1_val;
    logic [DATA_W-1:0]      dw2_val;

    logic                   disp_fire;
    logic [IDX_W-1:0]       free_idx;
    logic [NUM_FU-1:0]      iss_fire;
    logic [IDX_W-1:0]       sel_idx [NUM_FU];
    logic [CNT_W-1:0]       num_iss;

    assign disp_ready = (count < CNT_W'(NUM_ENTRIES)) && !flush;
    assign disp_fire  = disp_valid && disp_ready;

    // wakeup compare: ports scanned high to low so the lowest matching port wins
    always_comb begin
        wk1_hit = '0;
        wk2_hit = '0;
        dw1_hit = 1'b0;
        dw2_hit = 1'b0;
        dw1_val = '0;
        dw2_val = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            wk1_val[i] = '0;
            wk2_val[i] = '0;
        end
        for (int p = NUM_WB-1; p >= 0; p--) begin
            if (wb_valid[p]) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (valid[i] && !rdy1[i] && wb_tag[p*PREG_W +: PREG_W] == ent_t1[i]) begin
                        wk1_hit[i] = 1'b1;
                        wk1_val[i] = wb_val[p*DATA_W +: DATA_W];
                    end
                    if (valid[i] && !rdy2[i] && wb_tag[p*PREG_W +: PREG_W] == ent_t2[i]) begin
                        wk2_hit[i] = 1'b1;
                        wk2_val[i] = wb_val[p*DATA_W +: DATA_W];
                    end
                end
                if (!disp_rs1_rdy && wb_tag[p*PREG_W +: PREG_W] == disp_prs1) begin
                    dw1_hit = 1'b1;
                    dw1_val = wb_val[p*DATA_W +: DATA_W];
                end
                if (!disp_rs2_rdy && wb_tag[p*PREG_W +: PREG_W] == disp_prs2) begin
                    dw2_hit = 1'b1;
                    dw2_val = wb_val[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IDX_W'(i);
        end
    end

    // select: a candidate is oldest when no other candidate is older than it
    always_comb begin
        logic [NUM_ENTRIES-1:0] cand;
        logic                   blocked;
        cand    = '0;
        blocked = 1'b0;
        num_iss = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            iss_fire[k] = 1'b0;
            sel_idx[k]  = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cand[i] = valid[i] && rdy1[i] && rdy2[i] && fu_ready[k] &&
                          (ent_fu[i] == FU_W'(k));
            end
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                blocked = 1'b0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (cand[j] && older[j][i]) blocked = 1'b1;
                end
                if (cand[i] && !blocked) begin
                    iss_fire[k] = 1'b1;
                    sel_idx[k]  = IDX_W'(i);
                end
            end
            num_iss = num_iss + CNT_W'(iss_fire[k]);
        end
    end

    // issue register stage and entry control state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            rdy1      <= '0;
            rdy2      <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) older[i] <= '0;
            iss_valid <= '0;
            iss_data  <= '0;
            count     <= '0;
        end else if (flush) begin
            valid     <= '0;
            iss_valid <= '0;
            count     <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (wk1_hit[i]) rdy1[i] <= 1'b1;
                if (wk2_hit[i]) rdy2[i] <= 1'b1;
            end
            for (int k = 0; k < NUM_FU; k++) begin
                iss_valid[k] <= iss_fire[k];
                if (iss_fire[k]) begin
                    valid[sel_idx[k]] <= 1'b0;
                    iss_data[k*ISSUE_W +: ISSUE_W] <= {ent_opcode[sel_idx[k]], ent_prd[sel_idx[k]],
                                                       ent_v1[sel_idx[k]], ent_v2[sel_idx[k]],
                                                       ent_imm[sel_idx[k]], ent_rob[sel_idx[k]]};
                end
            end
            if (disp_fire) begin
                valid[free_idx] <= 1'b1;
                rdy1[free_idx]  <= disp_rs1_rdy | dw1_hit;
                rdy2[free_idx]  <= disp_rs2_rdy | dw2_hit;
                older[free_idx] <= '0;
                for (int j = 0; j < NUM_ENTRIES; j++) older[j][free_idx] <= valid[j];
            end
            count <= count + CNT_W'(disp_fire) - num_iss;
        end
    end

    // entry payload: data only, no reset needed since valid/ready gate its use
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (wk1_hit[i]) ent_v1[i] <= wk1_val[i];
            if (wk2_hit[i]) ent_v2[i] <= wk2_val[i];
        end
        if (disp_fire) begin
            ent_fu[free_idx]     <= disp_fu;
            ent_t1[free_idx]     <= disp_prs1;
            ent_t2[free_idx]     <= disp_prs2;
            ent_v1[free_idx]     <= dw1_hit ? dw1_val : disp_rs1_val;
            ent_v2[free_idx]     <= dw2_hit ? dw2_val : disp_rs2_val;
            ent_opcode[free_idx] <= disp_opcode;
            ent_prd[free_idx]    <= disp_prd;
            ent_imm[free_idx]    <= disp_imm;
            ent_rob[free_idx]    <= disp_rob;
        end
    end

endmodule

// File: tb/tb_issue_queue_ooo.sv
// Directed bench for issue_queue_ooo: dispatch, wakeup, age ordering,
// full-queue backpressure, flush, bad FU select and asynchronous reset.
module tb_issue_queue_ooo;
    localparam int N  = 16;
    localparam int NF = 3;
    localparam int NW = 2;
    localparam int DW = 32;
    localparam int PW = 6;
    localparam int RW = 6;
    localparam int FW = 2;
    localparam int IW = 7 + PW + 3*DW + RW;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           reset, flush, disp_valid, disp_ready;
    logic [6:0]     disp_opcode;
    logic [PW-1:0]  disp_prd, disp_prs1, disp_prs2;
    logic           disp_rs1_rdy, disp_rs2_rdy;
    logic [DW-1:0]  disp_rs1_val, disp_rs2_val, disp_imm;
    logic [RW-1:0]  disp_rob;
    logic [FW-1:0]  disp_fu;
    logic [NW-1:0]  wb_valid;
    logic [NW*PW-1:0] wb_tag;
    logic [NW*DW-1:0] wb_val;
    logic [NF-1:0]  fu_ready;
    logic [NF-1:0]  iss_valid;
    logic [NF*IW-1:0] iss_data;
    logic [CW-1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    issue_queue_ooo dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_prd(disp_prd),
        .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
        .disp_imm(disp_imm), .disp_rob(disp_rob), .disp_fu(disp_fu),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
        .fu_ready(fu_ready), .iss_valid(iss_valid), .iss_data(iss_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] slice(input int k);
        return iss_data[k*IW +: IW];
    endfunction
    function automatic logic [6:0]    f_op (input logic [IW-1:0] s); return s[IW-1 -: 7];         endfunction
    function automatic logic [PW-1:0] f_prd(input logic [IW-1:0] s); return s[RW+3*DW +: PW];     endfunction
    function automatic logic [DW-1:0] f_rs1(input logic [IW-1:0] s); return s[RW+2*DW +: DW];     endfunction
    function automatic logic [DW-1:0] f_rs2(input logic [IW-1:0] s); return s[RW+DW +: DW];       endfunction
    function automatic logic [DW-1:0] f_imm(input logic [IW-1:0] s); return s[RW +: DW];          endfunction
    function automatic logic [RW-1:0] f_rob(input logic [IW-1:0] s); return s[RW-1:0];            endfunction

    task automatic set_disp(input logic [6:0] op, input logic [PW-1:0] prd,
                            input logic [PW-1:0] p1, input logic r1, input logic [DW-1:0] v1,
                            input logic [PW-1:0] p2, input logic r2, input logic [DW-1:0] v2,
                            input logic [DW-1:0] imm, input logic [RW-1:0] rob, input logic [FW-1:0] fu);
        disp_valid   = 1'b1;
        disp_opcode  = op;
        disp_prd     = prd;
        disp_prs1    = p1;
        disp_rs1_rdy = r1;
        disp_rs1_val = v1;
        disp_prs2    = p2;
        disp_rs2_rdy = r2;
        disp_rs2_val = v2;
        disp_imm     = imm;
        disp_rob     = rob;
        disp_fu      = fu;
    endtask

    task automatic set_wb(input logic [NW-1:0] v, input logic [PW-1:0] t0, input logic [DW-1:0] d0,
                          input logic [PW-1:0] t1, input logic [DW-1:0] d1);
        wb_valid = v;
        wb_tag   = {t1, t0};
        wb_val   = {d1, d0};
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        fu_ready = '0;
        set_disp(7'h0, 6'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 32'd0, 6'd0, 2'd0);
        disp_valid = 1'b0;
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step();
        step();
        check("reset_count", count, 0);
        check("reset_iss_valid", iss_valid, 0);
        reset = 1'b0;
        check("post_reset_disp_ready", disp_ready, 1);

        // basic ready dispatch to unit 1
        fu_ready = 3'b111;
        set_disp(7'h33, 6'd3, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 32'h100, 6'd4, 2'd1);
        step();
        disp_valid = 1'b0;
        check("basic_count_after_disp", count, 1);
        check("basic_no_early_issue", iss_valid, 0);
        step();
        check("basic_iss_valid", iss_valid, 3'b010);
        check("basic_opcode", f_op(slice(1)), 7'h33);
        check("basic_prd", f_prd(slice(1)), 3);
        check("basic_rs1", f_rs1(slice(1)), 5);
        check("basic_rs2", f_rs2(slice(1)), 7);
        check("basic_imm", f_imm(slice(1)), 32'h100);
        check("basic_rob", f_rob(slice(1)), 4);
        check("basic_count_after_issue", count, 0);
        step();
        check("basic_iss_clears", iss_valid, 0);

        // wakeup on port 1 two cycles after dispatch
        set_disp(7'h13, 6'd5, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1, 32'd0, 6'd9, 2'd0);
        step();
        disp_valid = 1'b0;
        step();
        check("wake_wait", iss_valid, 0);
        set_wb(2'b10, 6'd0, 32'd0, 6'd12, 32'hDEAD);
        step();
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        check("wake_not_same_edge", iss_valid, 0);
        step();
        check("wake_iss_valid", iss_valid, 3'b001);
        check("wake_rs1", f_rs1(slice(0)), 32'hDEAD);
        check("wake_rob", f_rob(slice(0)), 9);

        // lowest matching wb port wins
        set_disp(7'h01, 6'd6, 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd2, 32'd0, 6'd10, 2'd1);
        step();
        disp_valid = 1'b0;
        set_wb(2'b11, 6'd20, 32'h111, 6'd20, 32'h222);
        step();
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step();
        check("port_prio_valid", iss_valid, 3'b010);
        check("port_prio_rs1", f_rs1(slice(1)), 32'h111);

        // age order: A before B on unit 0
        fu_ready = 3'b110;
        set_disp(7'h02, 6'd7, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 32'd0, 6'd1, 2'd0);
        step();
        set_disp(7'h03, 6'd8, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 32'd0, 6'd2, 2'd0);
        step();
        disp_valid = 1'b0;
        step();
        check("age_held", iss_valid, 0);
        check("age_count", count, 2);
        fu_ready = 3'b111;
        step();
        check("age_first_valid", iss_valid, 3'b001);
        check("age_first_rob", f_rob(slice(0)), 1);
        step();
        check("age_second_valid", iss_valid, 3'b001);
        check("age_second_rob", f_rob(slice(0)), 2);
        step();
        check("age_drained", count, 0);

        // fill to capacity, reject the 17th, then drain oldest-first
        fu_ready = 3'b000;
        for (int i = 0; i < N; i++) begin
            set_disp(7'h04, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 32'd0, RW'(i), 2'd2);
            step();
        end
        check("full_count", count, 16);
        check("full_disp_ready", disp_ready, 0);
        set_disp(7'h05, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 32'd0, 6'd63, 2'd2);
        step();
        disp_valid = 1'b0;
        check("full_17th_ignored", count, 16);
        fu_ready = 3'b100;
        step();
        check("full_first_issue", iss_valid, 3'b100);
        check("full_first_rob", f_rob(slice(2)), 0);
        check("full_count_after_issue", count, 15);
        check("full_ready_again", disp_ready, 1);
        for (int i = 1; i < N; i++) begin
            step();
            check("full_drain_rob", f_rob(slice(2)), 64'(i));
        end
        check("full_drained", count, 0);
        step();
        check("full_no_extra_issue", iss_valid, 0);

        // same-cycle wakeup capture at dispatch
        fu_ready = 3'b111;
        set_disp(7'h06, 6'd2, 6'd0, 1'b1, 32'd4, 6'd9, 1'b0, 32'd0, 32'd0, 6'd11, 2'd2);
        set_wb(2'b01, 6'd9, 32'd3, 6'd0, 32'd0);
        step();
        disp_valid = 1'b0;
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step();
        check("disp_wake_valid", iss_valid, 3'b100);
        check("disp_wake_rs2", f_rs2(slice(2)), 3);

        // flush with 8 waiting entries
        for (int i = 0; i < 8; i++) begin
            set_disp(7'h07, 6'd1, PW'(30 + i), 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 32'd0, RW'(i), 2'd0);
            step();
        end
        disp_valid = 1'b0;
        check("flush_pre_count", count, 8);
        flush = 1'b1;
        #1;
        check("flush_blocks_disp", disp_ready, 0);
        step();
        flush = 1'b0;
        check("flush_count", count, 0);
        check("flush_iss_valid", iss_valid, 0);
        set_wb(2'b11, 6'd30, 32'd1, 6'd31, 32'd2);
        step();
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        step();
        check("flush_no_late_issue", iss_valid, 0);
        check("flush_count_stays", count, 0);

        // unit select beyond NUM_FU is never issued
        set_disp(7'h08, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 32'd0, 6'd5, 2'd3);
        step();
        disp_valid = 1'b0;
        step();
        step();
        check("bad_fu_no_issue", iss_valid, 0);
        check("bad_fu_count", count, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("bad_fu_flushed", count, 0);

        // asynchronous reset mid-operation
        fu_ready = 3'b000;
        set_disp(7'h09, 6'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 32'd0, 6'd6, 2'd0);
        step();
        disp_valid = 1'b0;
        check("rst_mid_pre_count", count, 1);
        fu_ready = 3'b111;
        reset = 1'b1;
        #1;
        check("rst_async_count", count, 0);
        check("rst_async_iss_valid", iss_valid, 0);
        step();
        reset = 1'b0;
        check("rst_mid_disp_ready", disp_ready, 1);
        step();
        check("rst_mid_no_issue", iss_valid, 0);
        check("rst_mid_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
